// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: one partial product per clock, signed or
// unsigned per operation, start/busy/done handshake.
module seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] mul
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [PW-1:0]    acc, mcand, addend, sum;
  logic [WIDTH-1:0] mplier, x_mag, y_mag;
  logic [CW-1:0]    cnt;
  logic             neg, last, load;

  // Signed magnitudes stay WIDTH bits: |-2^(WIDTH-1)| fits as unsigned.
  assign x_mag  = (is_signed && x[WIDTH-1]) ? (~x + 1'b1) : x;
  assign y_mag  = (is_signed && y[WIDTH-1]) ? (~y + 1'b1) : y;
  assign last   = (state == RUN) && (cnt == CW'(WIDTH-1));
  assign load   = start && (state != RUN);
  assign addend = mplier[0] ? mcand : '0;
  assign sum    = acc + addend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Multiplicand shifts left and multiplier right, so bit cnt is always at
  // mplier[0] and the multiplicand is already aligned by cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      mul    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, x_mag};
      mplier <= y_mag;
      cnt    <= '0;
      neg    <= is_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
    end else if (state == RUN) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= last ? '0 : cnt + CW'(1);
      if (last) mul <= neg ? (~sum + 1'b1) : sum;
    end
  end
endmodule

// File: tb/tb_seq_mul.sv
// Bench for seq_mul: WIDTH=4 exhaustive, WIDTH=8 vectors, random and handshake corners.
module tb_seq_mul;
  logic clk, rst_n;
  logic start4, s4, busy4, done4;
  logic [3:0] x4, y4;
  logic [7:0] mul4;
  logic start8, s8, busy8, done8;
  logic [7:0] x8, y8;
  logic [15:0] mul8;

  int total = 0;
  int bad = 0;

  seq_mul #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start4), .is_signed(s4),
    .x(x4), .y(y4), .busy(busy4), .done(done4), .mul(mul4));
  seq_mul #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .is_signed(s8),
    .x(x8), .y(y8), .busy(busy8), .done(done8), .mul(mul8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        s;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m4(input logic s, input logic [3:0] a, input logic [3:0] b);
    int pa, pb;
    pa = s ? int'($signed(a)) : int'(a);
    pb = s ? int'($signed(b)) : int'(b);
    return 8'(pa * pb);
  endfunction

  function automatic logic [15:0] m8(input logic s, input logic [7:0] a, input logic [7:0] b);
    int pa, pb;
    pa = s ? int'($signed(a)) : int'(a);
    pb = s ? int'($signed(b)) : int'(b);
    return 16'(pa * pb);
  endfunction

  // Returns at the negedge where done is seen; lat counts negedges after the start edge.
  task automatic run4(input logic s, input logic [3:0] a, input logic [3:0] b,
                      output logic [7:0] r, output int lat);
    @(negedge clk); s4 = s; x4 = a; y4 = b; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0; x4 = 4'($urandom); y4 = 4'($urandom); s4 = ~s;
    lat = -1; r = '0;
    for (int k = 0; k < 40; k++) begin
      if (done4) begin lat = k; r = mul4; break; end
      @(negedge clk);
    end
  endtask

  task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] r, output int lat, output int bcnt);
    @(negedge clk); s8 = s; x8 = a; y8 = b; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom); s8 = ~s;
    lat = -1; bcnt = 0; r = '0;
    for (int k = 0; k < 40; k++) begin
      if (busy8) bcnt++;
      if (done8) begin lat = k; r = mul8; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0]  r4;
    logic [15:0] r8, cap;
    int lat, bcnt, dcnt, hold_err;
    logic s;
    logic [7:0] a, b;

    vecs[0] = '{"u ff*ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{"s -3*5",  1'b1, 8'hFD, 8'h05, 16'hFFF1};
    vecs[2] = '{"s -128*-128", 1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[3] = '{"s -128*127",  1'b1, 8'h80, 8'h7F, 16'hC080};
    vecs[4] = '{"s 0*-1",  1'b1, 8'h00, 8'hFF, 16'h0000};
    vecs[5] = '{"u 7*9",   1'b0, 8'h07, 8'h09, 16'h003F};

    rst_n = 1'b0; start4 = 0; s4 = 0; x4 = 0; y4 = 0; start8 = 0; s8 = 0; x8 = 0; y8 = 0;
    #3;
    chk("reset busy", busy8, 0);
    chk("reset done", done8, 0);
    chk("reset mul", mul8, 0);
    chk("reset mul4", mul4, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=4 exhaustive unsigned
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        run4(1'b0, 4'(i), 4'(j), r4, lat);
        chk("w4 product", r4, m4(1'b0, 4'(i), 4'(j)));
        chk("w4 latency", lat, 4);
      end
    run4(1'b0, 4'd15, 4'd13, r4, lat);
    chk("w4 15*13", r4, 8'hC3);
    chk("w4 15*13 latency", lat, 4);

    // WIDTH=8 directed table
    foreach (vecs[i]) begin
      run8(vecs[i].s, vecs[i].a, vecs[i].b, r8, lat, bcnt);
      chk(vecs[i].name, r8, vecs[i].exp);
      chk("w8 latency", lat, 8);
      chk("w8 busy cycles", bcnt, 8);
      chk("w8 busy at done", busy8, 0);
      @(negedge clk);
      chk("w8 done one cycle", done8, 0);
    end

    // WIDTH=8 random, both modes
    for (int n = 0; n < 200; n++) begin
      s = 1'($urandom_range(0, 1));
      a = 8'($urandom); b = 8'($urandom);
      run8(s, a, b, r8, lat, bcnt);
      chk("w8 random", r8, m8(s, a, b));
    end

    // start during RUN is ignored
    @(negedge clk); s8 = 0; x8 = 8'd7; y8 = 8'd9; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    dcnt = 0; cap = '0;
    for (int k = 0; k < 30; k++) begin
      if (k == 2) begin start8 = 1'b1; x8 = 8'd2; y8 = 8'd2; end
      if (k == 3) start8 = 1'b0;
      if (done8) begin dcnt++; cap = mul8; end
      @(negedge clk);
    end
    chk("mid-run start done count", dcnt, 1);
    chk("mid-run start result", cap, 16'h003F);

    // back-to-back with start held through DONE
    @(negedge clk); s8 = 0; x8 = 8'd7; y8 = 8'd9; start8 = 1'b1;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done8) begin lat = k; break; end
    end
    chk("b2b first done seen", lat, 8);
    chk("b2b first result", mul8, 16'h003F);
    chk("b2b busy in done", busy8, 0);
    x8 = 8'd10; y8 = 8'd10;
    @(negedge clk);
    chk("b2b busy again", busy8, 1);
    chk("b2b done dropped", done8, 0);
    start8 = 1'b0;
    hold_err = 0; lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (done8) begin lat = k; break; end
      if (mul8 !== 16'h003F) hold_err++;
      @(negedge clk);
    end
    chk("b2b mul held", hold_err, 0);
    chk("b2b second latency", lat, 8);
    chk("b2b second result", mul8, 16'h0064);

    // asynchronous reset in RUN cycle 4
    @(negedge clk); s8 = 0; x8 = 8'd7; y8 = 8'd9; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-reset busy", busy8, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", busy8, 0);
    chk("async reset done", done8, 0);
    chk("async reset mul", mul8, 0);
    @(negedge clk); rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (done8) dcnt++;
      @(negedge clk);
    end
    chk("no done after reset", dcnt, 0);
    run8(1'b0, 8'd12, 8'd11, r8, lat, bcnt);
    chk("post-reset result", r8, 16'h0084);
    chk("post-reset latency", lat, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
